// File: rtl/jt51_wrarb_if.sv
// Bus bundle between the write arbiter, its two requesters and the jt51 CPU
// port. The master side is the system (requesters plus chip), the slave side
// is the arbiter.
interface jt51_wrarb_if;
  logic [1:0] req_valid;
  logic [7:0] req_addr0;
  logic [7:0] req_addr1;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic [7:0] chip_dout;

  modport master (
    output req_valid, req_addr0, req_addr1, req_data0, req_data1, chip_dout,
    input  req_ready, cs_n, wr_n, a0, din
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_data0, req_data1, chip_dout,
    output req_ready, cs_n, wr_n, a0, din
  );
endinterface

// File: rtl/jt51_wrarb.sv
// jt51_wrarb: two-requester write arbiter for the jt51 CPU port. Each granted
// request becomes an address write (a0=0) followed by a data write (a0=1),
// then the block waits for the chip busy flag to clear before serving again.
module jt51_wrarb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jt51_wrarb_if.slave    bus,
  output logic           active,
  output logic           grant_id,
  output logic           err,
  input  logic           err_clr
);

  localparam int unsigned LIMIT = HOLDOFF + TIMEOUT;
  localparam int unsigned CW    = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    WAIT
  } state_t;

  state_t        st;
  logic          last;
  logic [CW-1:0] cnt;
  logic [7:0]    data_l;
  logic          pick;
  logic [6:0]    unused_dout;

  // Only the busy bit of the chip read-back matters here.
  assign unused_dout = bus.chip_dout[6:0];

  // Round-robin choice: a lone requester wins, on a tie the one not served last.
  always_comb begin
    pick = 1'b0;
    case (bus.req_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

  // Transaction sequencer; every state and bus output moves only on cen ticks,
  // except req_ready which self-clears on the following clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      bus.cs_n    <= 1'b1;
      bus.wr_n    <= 1'b1;
      bus.a0      <= 1'b0;
      bus.din     <= '0;
      bus.req_ready <= '0;
      active      <= 1'b0;
      grant_id    <= 1'b0;
      err         <= 1'b0;
      last        <= 1'b1;   // "last served = 1" makes requester 0 win the first tie
      cnt         <= '0;
      data_l      <= '0;
    end else begin
      bus.req_ready <= '0;
      if (cen) begin
        if (err_clr) err <= 1'b0;
        case (st)
          IDLE: begin
            if (|bus.req_valid) begin
              grant_id      <= pick;
              last          <= pick;
              bus.req_ready <= pick ? 2'b10 : 2'b01;
              data_l        <= pick ? bus.req_data1 : bus.req_data0;
              bus.din       <= pick ? bus.req_addr1 : bus.req_addr0;
              bus.a0        <= 1'b0;
              bus.cs_n      <= 1'b0;
              bus.wr_n      <= 1'b0;
              active        <= 1'b1;
              st            <= ADDR;
            end
          end
          ADDR: begin
            bus.cs_n <= 1'b1;
            bus.wr_n <= 1'b1;
            st       <= GAP;
          end
          GAP: begin
            bus.a0   <= 1'b1;
            bus.din  <= data_l;
            bus.cs_n <= 1'b0;
            bus.wr_n <= 1'b0;
            st       <= DATA;
          end
          DATA: begin
            bus.cs_n <= 1'b1;
            bus.wr_n <= 1'b1;
            cnt      <= '0;
            st       <= WAIT;
          end
          WAIT: begin
            // Busy is only trusted once the hold-off window has elapsed; the
            // timeout branch follows err_clr above so a coincident timeout wins.
            if (cnt >= CW'(HOLDOFF) && !bus.chip_dout[7]) begin
              active <= 1'b0;
              st     <= IDLE;
            end else if (cnt == CW'(LIMIT - 1)) begin
              err    <= 1'b1;
              active <= 1'b0;
              st     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/jt51_wrarb.md
# jt51_wrarb

Write arbiter and bus sequencer for the JT51 CPU port. It accepts register-write requests (address, data) from two independent requesters, for example a CPU bridge and a playback engine. It serialises each request into the chip's two-phase write: an address write with a0=0, then a data write with a0=1. It holds off the next transaction until the chip's busy flag (dout[7]) clears. It sits between the requesters and the jt51 bus pins and is paced by the same cen_p1 enable.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of cen ticks to wait for busy to clear before aborting; must be 1..65535.
- HOLDOFF, 2: number of cen ticks after the data strobe during which busy is ignored, covering the chip's busy-rise latency.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; connect to the jt51 cen_p1.
- req_valid  in  2  per-requester request pending; the requester holds it until it receives ready.
- req_addr0, req_addr1  in  8  register address for requester 0 / 1.
- req_data0, req_data1  in  8  register data for requester 0 / 1.
- req_ready  out  2  one-clk pulse on the bit of the granted requester; that request is consumed.
- cs_n, wr_n  out  1  jt51 chip select and write strobe, both active low, driven together.
- a0  out  1  jt51 address/data select.
- din  out  8  jt51 data bus.
- chip_dout  in  8  jt51 dout; only bit 7 (busy) is used.
- active  out  1  high from grant until return to IDLE.
- grant_id  out  1  requester currently or last served.
- err  out  1  sticky flag: a busy wait timed out.
- err_clr  in  1  clears err; if err_clr coincides with a new timeout, the timeout wins.

## Operation
- States: IDLE, ADDR, GAP, DATA, WAIT. All transitions occur only on clk edges with cen=1, except the req_ready pulse.
- IDLE, on a cen tick with req_valid≠0:
  - Select the requester using round-robin with a last-grant pointer. Bit 0 wins ties after reset. When both requesters are valid, the one not served last wins.
  - Latch the winner's addr/data, pulse its req_ready for exactly one clk, and set grant_id, active=1.
  - Drive cs_n=wr_n=0, a0=0, din=addr. Enter ADDR.
- ADDR, on the next cen tick: cs_n=wr_n=1, keeping a0 and din. Enter GAP. The address strobe therefore spans exactly one full cen period.
- GAP, on the next cen tick: a0=1, din=data, cs_n=wr_n=0. Enter DATA.
- DATA, on the next cen tick: cs_n=wr_n=1. Load the wait counter to 0. Enter WAIT.
- WAIT:
  - Each cen tick increments the counter.
  - Busy is ignored while the counter is below HOLDOFF.
  - After that, a cen tick seeing chip_dout[7]=0 returns the block to IDLE with active=0.
  - If the counter reaches HOLDOFF+TIMEOUT with busy still high, set err=1 and return to IDLE.
- Requests arriving outside IDLE stay pending; they are never dropped or double-acked.
- req_valid dropped before ready is treated as a withdrawn request; no write is issued.
- Reset values: cs_n=1, wr_n=1, a0=0, din=0, req_ready=0, active=0, grant_id=0, err=0, state IDLE, pointer favours requester 0.
- Reset mid-transaction: the block enters IDLE on the reset edge and releases the strobes immediately. No partial data write is reissued.

## Timing
- Latency from a cen tick seeing valid to the address strobe is 0 clk; the strobe is asserted at that same edge.
- With back-to-back cen (cen=1 every clk):
  - Address strobe: 1 clk.
  - Gap: 1 clk.
  - Data strobe: 1 clk.
  - Minimum transaction length: 4 + HOLDOFF cen ticks.
- din and a0 are stable for the entire strobe and for one cen period after it.
- req_ready is a single clk pulse coincident with the IDLE→ADDR edge.
- With cen=0 the block holds all state; strobe width scales with the cen period.

## Test plan
- Single write: req0 with addr 0x20, data 0xC7, cen every 2 clk, busy tied low.
  - Expect a0=0/din=0x20 for 2 clk, a gap, then a0=1/din=0xC7 for 2 clk.
  - Expect ready[0] pulsed once and the block back in IDLE after HOLDOFF ticks.
- Busy hold: busy high for 40 cen ticks after the data strobe.
  - Expect active to stay high.
  - Expect IDLE on the first tick with busy low, and err=0.
- Arbitration: both requesters valid continuously for 4 transactions.
  - Expect grants in the order 0,1,0,1.
  - Each ready pulses exactly once per grant.
- Timeout with TIMEOUT=8 and busy stuck high.
  - Expect err=1 after HOLDOFF+8 ticks and return to IDLE.
  - Asserting err_clr clears err.
- Reset asserted during the data strobe.
  - Expect cs_n=wr_n=1 and all outputs at their reset values on the next edge.
  - A pending request is re-granted cleanly after reset releases.
- cen=0 for 10 clk in mid-GAP: all outputs frozen, then the sequence resumes unchanged.
